scandoubler: RTL and testbench

Line-doubling stage between the Spectrum video generator and the HDMI/TMDS output path. It stores each 15.6 kHz source line (pixels strobed by `ce`) in one half of a ping-pong line buffer. While that line is being written, it replays the previous line twice from the other half at `ce2x`. The result is a ~31 kHz progressive stream with the same 24-bit colour, and regenerated, half-width horizontal sync.

---
 rtl/scandoubler.sv | 142 ++++++++++++++
 tb/tb_scandoubler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/scandoubler.sv
// Line doubler: each source line is written into one half of a ping-pong
// buffer while the previous line is replayed twice at the ce2x rate.
module scandoubler #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned HSW   = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        ce2x,
  input  logic [1:0]  blankIn,
  input  logic [1:0]  syncIn,
  input  logic [23:0] rgbIn,
  output logic [1:0]  blank,
  output logic [1:0]  sync,
  output logic [23:0] rgb
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] MAXC = AW'(DEPTH - 1);

  typedef enum logic [1:0] {RD_FIRST, RD_SECOND, RD_HOLD} rd_state_t;

  logic [24:0]   r_mem [2*DEPTH];
  logic [AW-1:0] r_wrCount;
  logic [AW-1:0] r_rdCount;
  logic [AW-1:0] r_lineLen;
  logic          r_bank;
  logic          r_prevHs;
  logic          r_prevVs;
  logic          r_prevVb;
  logic          r_vs;
  logic          r_vb;
  logic          r_seen;
  logic          r_valid;
  rd_state_t     r_state;

  logic          w_boundary;
  logic [AW-1:0] w_len;
  logic [AW-1:0] w_rdAddr;
  logic [AW-1:0] w_wrAddr;
  logic          w_rdBank;
  logic          w_wrBank;
  rd_state_t     w_phase;
  logic          w_last;
  logic          w_hold;
  logic          w_hs;
  logic          w_vs;
  logic          w_vb;
  logic          w_valid;
  logic [24:0]   w_rd;

  // A boundary restarts the read on the just-finished line in the same
  // cycle, so the read path uses the post-boundary view of bank/len/vsync.
  assign w_boundary = ce & ~syncIn[0] & r_prevHs;
  assign w_len      = w_boundary ? r_wrCount : r_lineLen;
  assign w_rdAddr   = w_boundary ? '0 : r_rdCount;
  assign w_rdBank   = w_boundary ? r_bank : ~r_bank;
  assign w_wrAddr   = w_boundary ? '0 : r_wrCount;
  assign w_wrBank   = w_boundary ? ~r_bank : r_bank;
  assign w_phase    = w_boundary ? RD_FIRST : r_state;
  assign w_last     = (w_rdAddr == (w_len - ONE));
  assign w_hold     = (w_phase == RD_HOLD);
  assign w_hs       = ((AW+2)'(w_rdAddr) + (AW+2)'(HSW)) >= (AW+2)'(w_len);
  assign w_vs       = w_boundary ? r_prevVs : r_vs;
  assign w_vb       = w_boundary ? r_prevVb : r_vb;
  assign w_valid    = r_valid | (w_boundary & r_seen);
  assign w_rd       = r_mem[{w_rdBank, w_rdAddr}];

  always_ff @(posedge clock) begin
    if (ce) begin
      r_mem[{w_wrBank, w_wrAddr}] <= {blankIn[0], rgbIn};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrCount <= '0;
      r_lineLen <= '0;
      r_bank    <= 1'b0;
      r_prevHs  <= 1'b0;
      r_prevVs  <= 1'b0;
      r_prevVb  <= 1'b0;
      r_vs      <= 1'b0;
      r_vb      <= 1'b0;
      r_seen    <= 1'b0;
      r_valid   <= 1'b0;
    end else if (ce) begin
      r_prevHs <= syncIn[0];
      r_prevVs <= syncIn[1];
      r_prevVb <= blankIn[1];
      if (w_boundary) begin
        r_wrCount <= ONE;
        r_bank    <= ~r_bank;
        r_lineLen <= r_wrCount;
        r_vs      <= r_prevVs;
        r_vb      <= r_prevVb;
        r_seen    <= 1'b1;
        r_valid   <= r_seen;
      end else if (r_wrCount != MAXC) begin
        r_wrCount <= r_wrCount + ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdCount <= '0;
      r_state   <= RD_FIRST;
      blank     <= '1;
      sync      <= '0;
      rgb       <= '0;
    end else if (ce2x) begin
      if (w_hold) begin
        r_state <= RD_HOLD;
      end else if (w_last) begin
        if (w_phase == RD_FIRST) begin
          r_rdCount <= '0;
          r_state   <= RD_SECOND;
        end else begin
          r_rdCount <= w_rdAddr;
          r_state   <= RD_HOLD;
        end
      end else begin
        r_rdCount <= w_rdAddr + ONE;
        r_state   <= w_phase;
      end

      if (!w_valid) begin
        blank <= '1;
        sync  <= '0;
        rgb   <= '0;
      end else begin
        rgb   <= w_rd[23:0];
        blank <= {w_vb, w_rd[24] | w_hold};
        sync  <= {w_vs, w_hs & ~w_hold};
      end
    end
  end

endmodule

// File: tb/tb_scandoubler.sv
// Randomized bench for scandoubler: a line-level model predicts every ce2x
// output tick; a monitor pops and compares those predictions.
module tb_scandoubler;

  localparam int DEPTH = 512;
  localparam int HSW   = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        ce;
  logic        ce2x;
  logic [1:0]  blankIn;
  logic [1:0]  syncIn;
  logic [23:0] rgbIn;
  logic [1:0]  blank;
  logic [1:0]  sync;
  logic [23:0] rgb;

  scandoubler #(.DEPTH(DEPTH), .HSW(HSW)) dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .ce2x    (ce2x),
    .blankIn (blankIn),
    .syncIn  (syncIn),
    .rgbIn   (rgbIn),
    .blank   (blank),
    .sync    (sync),
    .rgb     (rgb)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  b;
    logic [1:0]  s;
    logic [23:0] c;
    bit          care_rgb;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: lines are queues of stored pixels.
  int          nb;
  int          t;
  int          pL;
  bit          lastHs;
  logic [24:0] pdat[$];
  logic [24:0] cdat[$];
  bit          pvs, pvb, cvs, cvb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push_exp();
    exp_t        e;
    int          idx;
    logic [24:0] pix;
    if (nb < 2) begin
      e.b = 2'b11; e.s = 2'b00; e.c = 24'h0; e.care_rgb = 1'b1;
    end else if (t < 2 * pL) begin
      idx = t % pL;
      pix = pdat[idx];
      e.b = {pvb, pix[24]};
      e.s = {pvs, (idx >= pL - HSW)};
      e.c = pix[23:0];
      e.care_rgb = 1'b1;
    end else begin
      e.b = {pvb, 1'b1}; e.s = {pvs, 1'b0}; e.c = 24'h0; e.care_rgb = 1'b0;
    end
    q.push_back(e);
    t++;
  endtask

  task automatic cyc(input bit c, input bit c2);
    @(negedge clock);
    ce      = c;
    ce2x    = c2;
    rgbIn   = 24'($urandom);
    syncIn  = 2'($urandom);
    blankIn = 2'($urandom);
    if (c2) push_exp();
  endtask

  task automatic pixel(input logic [24:0] d, input bit hs, input bit vs, input bit vb);
    @(negedge clock);
    if (!hs && lastHs) begin
      nb++;
      t    = 0;
      pL   = (cdat.size() > DEPTH - 1) ? DEPTH - 1 : cdat.size();
      pdat = cdat;
      pvs  = cvs;
      pvb  = cvb;
      cdat.delete();
    end
    cdat.push_back(d);
    cvs     = vs;
    cvb     = vb;
    lastHs  = hs;
    rgbIn   = d[23:0];
    blankIn = {vb, d[24]};
    syncIn  = {vs, hs};
    ce      = 1'b1;
    ce2x    = 1'b1;
    push_exp();
    repeat ($urandom_range(0, 1)) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    repeat ($urandom_range(0, 1)) cyc(1'b0, 1'b0);
  endtask

  // Line of n pixels with input hsync on its last pixels; stop < n cuts it short.
  task automatic line(input int n, input bit vs, input bit vb, input int stop);
    int          hw;
    logic [24:0] d;
    hw = (n > 64) ? 32 : 8;
    for (int p = 0; p < stop; p++) begin
      d[24]   = (p >= n - n / 8);
      d[23:0] = 24'($urandom);
      pixel(d, (p >= n - hw), vs, vb);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cdat.delete();
    pdat.delete();
    nb = 0; t = 0; pL = 0; lastHs = 0;
    pvs = 0; pvb = 0; cvs = 0; cvb = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_blank"}, 32'(blank), 32'(2'b11));
    chk({tag, "_sync"},  32'(sync),  32'(2'b00));
    chk({tag, "_rgb"},   32'(rgb),   32'(24'h0));
  endtask

  exp_t me;
  always @(posedge clock) begin
    if (reset && ce2x) begin
      #1;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL underflow at %0t: got output tick expected none", $time);
      end else begin
        me = q.pop_front();
        chk("blank", 32'(blank), 32'(me.b));
        chk("sync",  32'(sync),  32'(me.s));
        if (me.care_rgb) chk("rgb", 32'(rgb), 32'(me.c));
      end
    end
  end

  initial begin
    reset = 1'b1; ce = 1'b0; ce2x = 1'b0;
    syncIn = '0; blankIn = '0; rgbIn = '0;
    model_reset();
    #3 reset = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clock);
    reset = 1'b1;

    repeat (3) line(448, 1'b0, 1'b0, 448);
    line(448, 1'b1, 1'b1, 448);
    line(448, 1'b0, 1'b0, 448);
    line(300, 1'b0, 1'b0, 300);
    line(448, 1'b0, 1'b1, 448);
    line(600, 1'b0, 1'b0, 600);
    line(448, 1'b0, 1'b0, 448);
    line(20,  1'b0, 1'b0, 20);
    line(448, 1'b0, 1'b0, 448);
    for (int i = 0; i < 4; i++) begin
      int n;
      n = $urandom_range(40, 520);
      line(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n);
    end
    line(448, 1'b0, 1'b0, 200);

    @(negedge clock);
    ce = 1'b0; ce2x = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clock);
    model_reset();
    reset = 1'b1;

    repeat (3) line(448, 1'b0, 1'b0, 448);
    line(100, 1'b1, 1'b0, 100);
    line(448, 1'b0, 1'b0, 448);
    line(448, 1'b0, 1'b0, 448);
    repeat (5) cyc(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
